i2c_cmd_sequencer: RTL and testbench

//  Upstream command front-end for the I2C master. Buffers host I2C commands
//  (7-bit addr, r/w, write byte) in a command FIFO and issues them one at a

---
 rtl/i2c_cmd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Host command front-end for the I2C master: command FIFO, one-at-a-time
// issue over new_dat/busy/done, watchdog abort, and response FIFO.
module i2c_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_ack_err,
    output logic       rsp_timeout,
    output logic       m_new_dat,
    output logic [6:0] m_addr,
    output logic       m_r_w,
    output logic [7:0] m_dat_in,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_ack_err,
    input  logic [7:0] m_dat_out,
    output logic       seq_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, WRITE_RSP
    } state_t;

    state_t state, state_nx;

    logic [15:0]   cmd_mem [DEPTH];
    logic [AW-1:0] cmd_wptr, cmd_rptr;
    logic [CW-1:0] cmd_cnt;
    logic [9:0]    rsp_mem [DEPTH];
    logic [AW-1:0] rsp_wptr, rsp_rptr;
    logic [CW-1:0] rsp_cnt;

    logic [WW-1:0] wd;
    logic [7:0]    cap_rdata;
    logic          cap_ack, cap_to;

    logic cmd_push, cmd_pop, rsp_push, rsp_pop;
    logic rsp_full, waiting, wd_exp;
    logic load, cap_done, cap_tmo;

    assign cmd_ready = cmd_cnt != CW'(DEPTH);
    assign cmd_push  = cmd_valid && cmd_ready;
    assign rsp_valid = rsp_cnt != '0;
    assign rsp_full  = rsp_cnt == CW'(DEPTH);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign waiting   = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign wd_exp    = waiting && (wd == WW'(TIMEOUT_CYCLES - 1));
    assign seq_busy  = state != IDLE;

    assign {rsp_rdata, rsp_ack_err, rsp_timeout} =
        rsp_valid ? rsp_mem[rsp_rptr] : 10'h000;

    // FIFO storage: written on push, no reset needed
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wptr] <= {cmd_addr, cmd_rw, cmd_wdata};
        if (rsp_push) rsp_mem[rsp_wptr] <= {cap_rdata, cap_ack, cap_to};
    end

    // FIFO pointers and occupancy counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wptr <= '0;
            cmd_rptr <= '0;
            cmd_cnt  <= '0;
            rsp_wptr <= '0;
            rsp_rptr <= '0;
            rsp_cnt  <= '0;
        end else begin
            if (cmd_push) cmd_wptr <= cmd_wptr + AW'(1);
            if (cmd_pop)  cmd_rptr <= cmd_rptr + AW'(1);
            if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + CW'(1);
            else if (!cmd_push && cmd_pop) cmd_cnt <= cmd_cnt - CW'(1);
            if (rsp_push) rsp_wptr <= rsp_wptr + AW'(1);
            if (rsp_pop)  rsp_rptr <= rsp_rptr + AW'(1);
            if (rsp_push && !rsp_pop)      rsp_cnt <= rsp_cnt + CW'(1);
            else if (!rsp_push && rsp_pop) rsp_cnt <= rsp_cnt - CW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state and control strobes
    always_comb begin
        state_nx  = state;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        load      = 1'b0;
        cap_done  = 1'b0;
        cap_tmo   = 1'b0;
        m_new_dat = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_cnt != '0 && !rsp_full) begin
                    cmd_pop  = 1'b1;
                    load     = 1'b1;
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                m_new_dat = 1'b1;
                state_nx  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (m_done) begin
                    cap_done = 1'b1;
                    state_nx = WRITE_RSP;
                end else if (wd_exp) begin
                    cap_tmo  = 1'b1;
                    state_nx = WRITE_RSP;
                end else if (m_busy) begin
                    state_nx = WAIT_DONE;
                end else begin
                    m_new_dat = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (m_done) begin
                    cap_done = 1'b1;
                    state_nx = WRITE_RSP;
                end else if (wd_exp) begin
                    cap_tmo  = 1'b1;
                    state_nx = WRITE_RSP;
                end
            end
            WRITE_RSP: begin
                rsp_push = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request registers, watchdog and completion capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr    <= '0;
            m_r_w     <= 1'b0;
            m_dat_in  <= '0;
            wd        <= '0;
            cap_rdata <= '0;
            cap_ack   <= 1'b0;
            cap_to    <= 1'b0;
        end else begin
            if (load) {m_addr, m_r_w, m_dat_in} <= cmd_mem[cmd_rptr];
            if (state == LAUNCH) wd <= '0;
            else if (waiting)    wd <= wd + WW'(1);
            if (cap_done) begin
                cap_rdata <= m_r_w ? m_dat_out : 8'h00;
                cap_ack   <= m_ack_err;
                cap_to    <= 1'b0;
            end else if (cap_tmo) begin
                cap_rdata <= 8'h00;
                cap_ack   <= 1'b0;
                cap_to    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: behavioural I2C master model,
// response scoreboard, vector table and multi-cycle corner sequences.
module tb_i2c_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_ack_err, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       m_new_dat, m_r_w, m_busy, m_done, m_ack_err;
    logic [6:0] m_addr;
    logic [7:0] m_dat_in, m_dat_out;
    logic       seq_busy;

    i2c_cmd_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_ack_err(rsp_ack_err),
        .rsp_timeout(rsp_timeout),
        .m_new_dat(m_new_dat), .m_addr(m_addr), .m_r_w(m_r_w),
        .m_dat_in(m_dat_in), .m_busy(m_busy), .m_done(m_done),
        .m_ack_err(m_ack_err), .m_dat_out(m_dat_out),
        .seq_busy(seq_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       ack;
        logic       to;
    } vec_t;

    vec_t        vecs [6];
    logic [9:0]  exp_q [$];
    logic [15:0] lq [$];
    int          errors = 0;
    int          checks = 0;
    logic        hang = 1'b0;
    logic [9:0]  mon_e;
    logic [15:0] le;
    int          ms = 0;
    int          cnt = 0;
    logic [6:0]  cur_addr;
    logic        cur_rw;

    function automatic logic [7:0] rd_model(input logic [6:0] a);
        return (a == 7'h68) ? 8'hA5 : ({1'b0, a} ^ 8'h5A);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each popped response against the queue head
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp", {rsp_rdata, rsp_ack_err, rsp_timeout}, mon_e);
            end
        end
    end

    // Master model: busy for 3 cycles, then done pulse with busy low
    initial begin
        m_busy = 0; m_done = 0; m_ack_err = 0; m_dat_out = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ms = 0; m_busy = 0; m_done = 0;
                lq.delete();
            end else begin
                m_done = 0;
                case (ms)
                    0: if (m_new_dat) begin
                        if (lq.size() == 0) begin
                            check("launch_unexpected", 1, 0);
                        end else begin
                            le = lq.pop_front();
                            check("launch_addr_rw", {m_addr, m_r_w}, le[15:8]);
                            if (!m_r_w) check("launch_wdata", m_dat_in, le[7:0]);
                        end
                        cur_addr = m_addr;
                        cur_rw   = m_r_w;
                        if (hang) ms = 2;
                        else begin m_busy = 1; cnt = 3; ms = 1; end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            m_busy    = 0;
                            m_done    = 1;
                            m_ack_err = (cur_addr == 7'h7F);
                            m_dat_out = cur_rw ? rd_model(cur_addr) : 8'hEE;
                            ms = 0;
                        end
                    end
                    default: if (!seq_busy) ms = 0;
                endcase
            end
        end
    end

    task automatic send(input logic [6:0] a, input logic rw,
                        input logic [7:0] d, input logic [7:0] er,
                        input logic ea, input logic et);
        int n;
        cmd_valid = 1; cmd_addr = a; cmd_rw = rw; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 500) begin
            check("cmd_accept_timeout", 0, 1);
            cmd_valid = 0;
        end else begin
            exp_q.push_back({er, ea, et});
            lq.push_back({a, rw, d});
            @(posedge clk); #1;
            cmd_valid = 0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || seq_busy) && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        check("drain_done", n < 1000, 1);
    endtask

    initial begin
        int bc, nc;
        vecs[0] = '{7'h50, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{7'h68, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0};
        vecs[2] = '{7'h7F, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{7'h22, 1'b0, 8'h99, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{7'h13, 1'b1, 8'h00, 8'h49, 1'b0, 1'b0};
        vecs[5] = '{7'h7F, 1'b1, 8'h00, 8'h25, 1'b1, 1'b0};

        rst = 1; cmd_valid = 0; cmd_addr = 0; cmd_rw = 0; cmd_wdata = 0;
        rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags",
              {cmd_ready, rsp_valid, m_new_dat, seq_busy, rsp_ack_err, rsp_timeout},
              6'b100000);
        check("reset_bus", {m_addr, m_r_w, m_dat_in, rsp_rdata}, 0);
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            send(vecs[i].addr, vecs[i].rw, vecs[i].wdata,
                 vecs[i].rdata, vecs[i].ack, vecs[i].to);
        drain();

        send(7'h50, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0);
        check("lat_n1_new_dat", m_new_dat, 0);
        @(posedge clk); #1;
        check("lat_n2_new_dat", m_new_dat, 1);
        drain();

        rsp_ready = 0;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].addr, vecs[i].rw, vecs[i].wdata,
                 vecs[i].rdata, vecs[i].ack, vecs[i].to);
            if (i == 4) check("bp_cmd_full", cmd_ready, 0);
        end
        repeat (100) @(posedge clk);
        #1;
        check("bp_stall_idle", {seq_busy, m_new_dat}, 2'b00);
        check("bp_state", {cmd_ready, rsp_valid}, 2'b11);
        check("bp_pending", exp_q.size(), 6);
        rsp_ready = 1;
        drain();

        hang = 1;
        send(7'h44, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
        bc = 0; nc = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (seq_busy) bc++;
            if (m_new_dat) nc++;
        end
        check("to_busy_cycles", bc, 66);
        check("to_newdat_cycles", nc, 64);
        hang = 0;
        drain();

        send(7'h31, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0);
        bc = 0;
        while (!m_busy && bc < 100) begin
            @(posedge clk); #1; bc++;
        end
        check("rst_reach_busy", m_busy, 1);
        @(posedge clk); #1;
        rst = 1;
        exp_q.delete();
        #2;
        check("rst_mid_flags",
              {cmd_ready, rsp_valid, m_new_dat, seq_busy, rsp_ack_err, rsp_timeout},
              6'b100000);
        check("rst_mid_bus", {m_addr, m_r_w, m_dat_in, rsp_rdata}, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        send(7'h2A, 1'b1, 8'h00, 8'h70, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
